// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, frame constants and default widths for the serial master/slave pair
package bus_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_SLAVE_ID_WIDTH = 2;
  localparam int DEF_MAX_LEN = 256;
  localparam logic [2:0] START_BITS = 3'b111;
  typedef enum logic [2:0] {IDLE, CTRL, WAIT, WDATA, RDATA, FINISH} state_t;
  function automatic int frame_len(input int sw, input int aw);
    return 5 + sw + aw;
  endfunction
  localparam int FRAME_LEN = frame_len(DEF_SLAVE_ID_WIDTH, DEF_ADDR_WIDTH);
endpackage

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-load, MSB-first serializer
module piso_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout
);
  logic [W-1:0] sr;
  // load wins over shift; the MSB is always the bit on the wire
  always_ff @(posedge clk)
    if (!rstN) sr <= '0;
    else if (load) sr <= din;
    else if (shift) sr <= {sr[W-2:0], 1'b0};
  assign dout = sr[W-1];
endmodule

// File: rtl/master_port.sv
// master_port: parallel command/data to serial control-frame and data-word bus master
module master_port
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SLAVE_ID_WIDTH = DEF_SLAVE_ID_WIDTH,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SLAVE_ID_WIDTH-1:0] cmd_slave_id,
  input  logic                      cmd_write,
  input  logic                      cmd_burst,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [$clog2(MAX_LEN):0]  cmd_len,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      done,
  output logic                      control,
  output logic                      wD,
  output logic                      valid,
  output logic                      last,
  input  logic                      rD,
  input  logic                      ready
);
  localparam int LW = $clog2(MAX_LEN) + 1;
  localparam int FL = frame_len(SLAVE_ID_WIDTH, ADDR_WIDTH);
  localparam int CW = $clog2((FL > DATA_WIDTH ? FL : DATA_WIDTH) + 1);
  localparam int SW = $clog2(DATA_WIDTH);
  state_t state, nxt;
  logic [CW-1:0] bit_cnt;
  logic [LW-1:0] word_cnt, len, len_in;
  logic [SW-1:0] samp_cnt;
  logic [DATA_WIDTH-1:0] rsh;
  logic [FL-1:0] frame;
  logic wr_q, have, smp, frame_bit, word_bit, cmd_fire, bit_end, last_word;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign frame = {START_BITS, cmd_slave_id, cmd_write, cmd_burst, cmd_addr};
  assign len_in = (!cmd_burst || cmd_len == '0) ? LW'(1) : (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign bit_end = bit_cnt == CW'(DATA_WIDTH - 1);
  assign last_word = word_cnt == len - 1'b1;
  assign last = valid & last_word;
  piso_shifter #(.W(FL)) u_frame (
    .clk(clk), .rstN(rstN), .load(cmd_fire), .shift(state == CTRL), .din(frame), .dout(frame_bit)
  );
  piso_shifter #(.W(DATA_WIDTH)) u_word (
    .clk(clk), .rstN(rstN), .load(wr_ready), .shift(valid && state == WDATA), .din(wr_data), .dout(word_bit)
  );
  // state register
  always_ff @(posedge clk)
    if (!rstN) state <= IDLE;
    else state <= nxt;
  // next state and serial/handshake outputs
  always_comb begin
    nxt = state;
    cmd_ready = 1'b0;
    wr_ready = 1'b0;
    valid = 1'b0;
    control = 1'b0;
    wD = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        nxt = cmd_valid ? CTRL : IDLE;
      end
      CTRL: begin
        control = frame_bit;
        nxt = bit_cnt == CW'(FL - 1) ? WAIT : CTRL;
      end
      WAIT: nxt = ready ? (wr_q ? WDATA : RDATA) : WAIT;
      WDATA: begin
        wD = word_bit;
        wr_ready = !have && wr_valid;
        valid = have && ready;
        nxt = (valid && bit_end && last_word) ? FINISH : WDATA;
      end
      RDATA: begin
        valid = ready && word_cnt < len;
        nxt = (word_cnt == len && smp) ? FINISH : RDATA;
      end
      FINISH: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // command latch, bit/word counters and read-word assembly
  always_ff @(posedge clk)
    if (!rstN) begin
      bit_cnt <= '0;
      word_cnt <= '0;
      len <= '0;
      wr_q <= 1'b0;
      have <= 1'b0;
      smp <= 1'b0;
      samp_cnt <= '0;
      rsh <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      smp <= state == RDATA && valid;
      if (cmd_fire) begin
        wr_q <= cmd_write;
        len <= len_in;
        word_cnt <= '0;
        bit_cnt <= '0;
        have <= 1'b0;
        samp_cnt <= '0;
      end
      if (state == CTRL) bit_cnt <= bit_cnt == CW'(FL - 1) ? '0 : bit_cnt + 1'b1;
      if (wr_ready) have <= 1'b1;
      if (valid) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
        if (bit_end) begin
          word_cnt <= word_cnt + 1'b1;
          have <= 1'b0;
        end
      end
      if (smp) begin
        rsh <= {rsh[DATA_WIDTH-2:0], rD};
        samp_cnt <= samp_cnt + 1'b1;
        if (samp_cnt == SW'(DATA_WIDTH - 1)) begin
          rd_data <= {rsh[DATA_WIDTH-2:0], rD};
          rd_valid <= 1'b1;
          samp_cnt <= '0;
        end
      end
    end
endmodule
